// File: rtl/reg_bank_stream.sv
// Byte-stream register bank: framed command byte then auto-incrementing write/read bursts.
// Optional build macro REGFILE_LOCK_EN: bit 0 of the last register locks writes to all others.
module reg_bank_stream #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_i,
    input  logic [DATA_W-1:0]       byte_i,
    input  logic                    byte_valid_i,
    output logic [DATA_W-1:0]       rd_data_o,
    output logic                    rd_valid_o,
    output logic [DEPTH*DATA_W-1:0] regs_o,
    output logic [DEPTH-1:0]        wr_strobe_o,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int                ADDR_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_ERR} state_t;

    state_t                         r_state, w_state_nxt;
    logic [DEPTH-1:0][DATA_W-1:0]   r_regs;
    logic [ADDR_W-1:0]              r_ptr;
    logic [DATA_W-1:0]              r_rd_data;
    logic                           r_rd_valid;
    logic [DEPTH-1:0]               r_strb;
    logic                           r_err;

    logic                           w_acc;
    logic [ADDR_W-1:0]              w_cmd_addr;
    logic                           w_cmd_rd;
    logic                           w_cmd_bad;
    logic [ADDR_W-1:0]              w_cmd_inc;
    logic [ADDR_W-1:0]              w_ptr_inc;
    logic                           w_wr_drop;

    assign w_acc      = frame_i & byte_valid_i;
    assign w_cmd_addr = byte_i[ADDR_W-1:0];
    assign w_cmd_rd   = byte_i[DATA_W-1];
    assign w_cmd_bad  = {1'b0, w_cmd_addr} >= DEPTH_L;
    assign w_cmd_inc  = (w_cmd_addr == LAST) ? '0 : w_cmd_addr + ADDR_W'(1);
    assign w_ptr_inc  = (r_ptr == LAST) ? '0 : r_ptr + ADDR_W'(1);

`ifdef REGFILE_LOCK_EN
    // The lock register itself stays writable so the lock can always be released.
    assign w_wr_drop = r_regs[DEPTH-1][0] && (r_ptr != LAST);
`else
    assign w_wr_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!frame_i) begin
            w_state_nxt = S_IDLE;
        end else if (r_state == S_IDLE && w_acc) begin
            if (w_cmd_bad)     w_state_nxt = S_ERR;
            else if (w_cmd_rd) w_state_nxt = S_READ;
            else               w_state_nxt = S_WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs     <= '0;
            r_ptr      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_strb     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_strb     <= '0;
            if (w_acc) begin
                case (r_state)
                    S_IDLE: begin
                        r_err <= w_cmd_bad;
                        r_ptr <= w_cmd_addr;
                        // A read command also returns the first word, so ptr skips ahead.
                        if (!w_cmd_bad && w_cmd_rd) begin
                            r_rd_data  <= r_regs[w_cmd_addr];
                            r_rd_valid <= 1'b1;
                            r_ptr      <= w_cmd_inc;
                        end
                    end
                    S_WRITE: begin
                        if (w_wr_drop) begin
                            r_err <= 1'b1;
                        end else begin
                            r_regs[r_ptr] <= byte_i;
                            r_strb[r_ptr] <= 1'b1;
                        end
                        r_ptr <= w_ptr_inc;
                    end
                    S_READ: begin
                        r_rd_data  <= r_regs[r_ptr];
                        r_rd_valid <= 1'b1;
                        r_ptr      <= w_ptr_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;
    assign regs_o      = r_regs;
    assign wr_strobe_o = r_strb;
    assign busy_o      = (r_state != S_IDLE);
    assign err_o       = r_err;
endmodule

// File: tb/tb_reg_bank_stream.sv
// Directed bench for reg_bank_stream: vector table on a DEPTH=16 instance,
// hand sequences for out-of-range addressing (DEPTH=12), lock and mid-burst reset.
module tb_reg_bank_stream;
`ifdef REGFILE_LOCK_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame = 1'b0, bvld = 1'b0;
    logic [7:0]   bdat = 8'h00;
    logic [7:0]   rd_data;
    logic         rd_valid, busy, err;
    logic [127:0] regs;
    logic [15:0]  strb;

    logic         frame12 = 1'b0, bvld12 = 1'b0;
    logic [7:0]   bdat12 = 8'h00;
    logic [7:0]   rd_data12;
    logic         rd_valid12, busy12, err12;
    logic [95:0]  regs12;
    logic [11:0]  strb12;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_bank_stream #(.DATA_W(8), .DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .frame_i(frame), .byte_i(bdat), .byte_valid_i(bvld),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .regs_o(regs),
        .wr_strobe_o(strb), .busy_o(busy), .err_o(err));

    reg_bank_stream #(.DATA_W(8), .DEPTH(12)) u_dut12 (
        .clk(clk), .rst(rst), .frame_i(frame12), .byte_i(bdat12), .byte_valid_i(bvld12),
        .rd_data_o(rd_data12), .rd_valid_o(rd_valid12), .regs_o(regs12),
        .wr_strobe_o(strb12), .busy_o(busy12), .err_o(err12));

    typedef struct {
        logic       f, v;
        logic [7:0] b;
        logic       busy, err, rdv;
        logic [7:0] rdd;
        logic [15:0] strb;
        int         ri;
        logic [7:0] rv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic f, logic v, logic [7:0] b, logic bz, logic er,
                                logic rv_, logic [7:0] rdd, logic [15:0] st, int ri, logic [7:0] rv);
        vec_t t;
        t.f = f; t.v = v; t.b = b; t.busy = bz; t.err = er; t.rdv = rv_;
        t.rdd = rdd; t.strb = st; t.ri = ri; t.rv = rv;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic f, input logic v, input logic [7:0] b);
        @(negedge clk);
        frame = f; bvld = v; bdat = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step12(input logic f, input logic v, input logic [7:0] b);
        @(negedge clk);
        frame12 = f; bvld12 = v; bdat12 = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rg(int i);
        return regs[i*8 +: 8];
    endfunction

    initial begin
        // write 3,4 / read back from 3 / abort / wrap
        tbl.push_back(mk(1,1,8'h03, 1,0,0,8'h00,16'h0000, 3,8'h00));
        tbl.push_back(mk(1,1,8'hAA, 1,0,0,8'h00,16'h0008, 3,8'hAA));
        tbl.push_back(mk(1,1,8'hBB, 1,0,0,8'h00,16'h0010, 4,8'hBB));
        tbl.push_back(mk(0,0,8'h00, 0,0,0,8'h00,16'h0000, 4,8'hBB));
        tbl.push_back(mk(1,1,8'h83, 1,0,1,8'hAA,16'h0000, 3,8'hAA));
        tbl.push_back(mk(1,1,8'h5A, 1,0,1,8'hBB,16'h0000, 4,8'hBB));
        tbl.push_back(mk(1,1,8'h00, 1,0,1,8'h00,16'h0000, 5,8'h00));
        tbl.push_back(mk(1,0,8'h77, 1,0,0,8'h00,16'h0000, 5,8'h00));
        tbl.push_back(mk(0,0,8'h00, 0,0,0,8'h00,16'h0000, 4,8'hBB));
        tbl.push_back(mk(1,1,8'h02, 1,0,0,8'h00,16'h0000, 2,8'h00));
        tbl.push_back(mk(1,1,8'h55, 1,0,0,8'h00,16'h0004, 2,8'h55));
        tbl.push_back(mk(0,1,8'h66, 0,0,0,8'h00,16'h0000, 3,8'hAA));
        tbl.push_back(mk(0,0,8'h00, 0,0,0,8'h00,16'h0000, 3,8'hAA));
        tbl.push_back(mk(1,1,8'h82, 1,0,1,8'h55,16'h0000, 2,8'h55));
        tbl.push_back(mk(0,0,8'h00, 0,0,0,8'h55,16'h0000, 2,8'h55));
        tbl.push_back(mk(1,1,8'h0F, 1,0,0,8'h55,16'h0000, 15,8'h00));
        tbl.push_back(mk(1,1,8'h11, 1,0,0,8'h55,16'h8000, 15,8'h11));
        tbl.push_back(mk(1,1,8'h22, 1,LK,0,8'h55, LK ? 16'h0000 : 16'h0001, 0, LK ? 8'h00 : 8'h22));
        tbl.push_back(mk(0,0,8'h00, 0,LK,0,8'h55,16'h0000, 0, LK ? 8'h00 : 8'h22));
        tbl.push_back(mk(1,1,8'h8F, 1,0,1,8'h11,16'h0000, 15,8'h11));
        tbl.push_back(mk(1,1,8'h00, 1,0,1, LK ? 8'h00 : 8'h22,16'h0000, 15,8'h11));
        tbl.push_back(mk(0,0,8'h00, 0,0,0, LK ? 8'h00 : 8'h22,16'h0000, 0, LK ? 8'h00 : 8'h22));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset regs", regs, 128'h0);
        chk("reset outs", {rd_data, rd_valid, strb, busy, err}, '0);
        chk("reset regs12", {32'h0, regs12}, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].f, tbl[i].v, tbl[i].b);
            chk($sformatf("v%0d busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d err", i), err, tbl[i].err);
            chk($sformatf("v%0d rd_valid", i), rd_valid, tbl[i].rdv);
            chk($sformatf("v%0d rd_data", i), rd_data, tbl[i].rdd);
            chk($sformatf("v%0d strobe", i), strb, tbl[i].strb);
            chk($sformatf("v%0d reg%0d", i, tbl[i].ri), rg(tbl[i].ri), tbl[i].rv);
        end

        // Out-of-range command on a 12-entry bank
        step12(1, 1, 8'h0C);
        chk("d12 err after bad cmd", err12, 1'b1);
        chk("d12 busy", busy12, 1'b1);
        step12(1, 1, 8'h77);
        chk("d12 err sticky", err12, 1'b1);
        chk("d12 no strobe", strb12, 12'h000);
        chk("d12 regs unchanged", {32'h0, regs12}, 128'h0);
        step12(0, 0, 8'h00);
        chk("d12 idle after frame", busy12, 1'b0);
        step12(1, 1, 8'h00);
        chk("d12 err cleared", err12, 1'b0);
        step12(1, 1, 8'h44);
        chk("d12 write reg0", {strb12, regs12[7:0]}, {12'h001, 8'h44});
        step12(0, 0, 8'h00);

`ifdef REGFILE_LOCK_EN
        step(1, 1, 8'h0F);
        step(1, 1, 8'h01);
        chk("lock set reg15", {strb, rg(15)}, {16'h8000, 8'h01});
        step(0, 0, 8'h00);
        step(1, 1, 8'h00);
        step(1, 1, 8'h99);
        chk("locked write dropped", {strb, rg(0)}, {16'h0000, 8'h00});
        chk("locked write err", err, 1'b1);
        step(0, 0, 8'h00);
        step(1, 1, 8'h0F);
        step(1, 1, 8'h00);
        chk("unlock reg15", {strb, rg(15), err}, {16'h8000, 8'h00, 1'b0});
        step(0, 0, 8'h00);
        step(1, 1, 8'h00);
        step(1, 1, 8'h99);
        chk("unlocked write", {strb, rg(0), err}, {16'h0001, 8'h99, 1'b0});
        step(0, 0, 8'h00);
`endif

        // Reset in the middle of a write burst, with rd_data holding a non-zero value
        step(1, 1, 8'h82);
        chk("pre-rst read", {rd_valid, rd_data}, {1'b1, 8'h55});
        step(0, 0, 8'h00);
        step(1, 1, 8'h05);
        step(1, 1, 8'h33);
        chk("pre-rst write reg5", rg(5), 8'h33);
        @(negedge clk);
        rst = 1'b1; frame = 1'b1; bvld = 1'b1; bdat = 8'h44;
        @(posedge clk);
        #1;
        chk("mid-burst rst regs", regs, 128'h0);
        chk("mid-burst rst outs", {rd_data, rd_valid, strb, busy, err}, '0);
        @(negedge clk);
        rst = 1'b0; bdat = 8'h85;
        @(posedge clk);
        #1;
        chk("post-rst byte is cmd", {busy, rd_valid, rd_data, rg(5)}, {1'b1, 1'b1, 8'h00, 8'h00});
        step(0, 0, 8'h00);
        chk("post-rst idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
